mul_rr_scheduler: RTL and testbench

Round-robin scheduler that lets N_REQ product-node requesters share one pipelined FP32 multiplier. It accepts operand pairs from the requesters and issues at most one per cycle. Each issued operation carries an owner tag through a shadow shift register, and each result is steered into a per-requester response FIFO. Credit-based issue control prevents any result from being dropped, because the multiplier cannot stall.

---
 rtl/mul_rr_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_mul_rr_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_rr_scheduler.sv
// mul_rr_scheduler: round-robin sharing of one non-stallable pipelined FP32
// multiplier among N_REQ requesters. Each issued operation is paired with an
// owner tag that travels alongside the multiplier. Each result is steered into
// that owner's response FIFO. Per-requester credits (FIFO space minus results
// still in flight) guarantee that every result has a FIFO slot when it returns.
// LAT >= 1 and DEPTH is a power of two >= 2.
module mul_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter int LAT   = 3,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [64*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic [63:0]           mul_in,
    output logic                  mul_in_stb,
    input  logic [31:0]           mul_z,
    input  logic                  mul_z_stb,
    output logic [N_REQ-1:0]      resp_valid,
    output logic [32*N_REQ-1:0]   resp_data,
    input  logic [N_REQ-1:0]      resp_ready,
    output logic                  busy,
    output logic                  sync_err
);
    localparam int IDW = $clog2(N_REQ);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Arbitration and issue state.
    logic [IDW-1:0]   ptr_reg;
    logic [63:0]      mul_in_reg;
    logic             mul_in_stb_reg;
    logic             sync_err_reg;

    // Owner tags shadowing the multiplier pipeline; the last stage retires.
    logic [LAT:0]     tag_valid_reg;
    logic [IDW-1:0]   tag_id_reg [LAT+1];

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] nonempty;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_idx;
    logic             grant_any;
    logic             accept;
    logic             retire_valid;
    logic [IDW-1:0]   retire_id;

    assign retire_valid = tag_valid_reg[LAT];
    assign retire_id    = tag_id_reg[LAT];

    // Round-robin search: first eligible requester after the last winner.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = ptr_reg;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr_reg) + k) % N_REQ;
            if (!grant_any && eligible[idx]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(idx);
            end
        end
    end

    // Nothing is granted while reset is asserted, even though state is reset.
    assign accept = grant_any & ~rst;

    // One-hot grant vector presented as req_ready.
    always_comb begin
        grant = '0;
        if (accept) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign req_ready = grant;

    // Operand register feeding the multiplier; holds its value on idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg        <= IDW'(N_REQ - 1);
            mul_in_reg     <= '0;
            mul_in_stb_reg <= 1'b0;
        end else begin
            mul_in_stb_reg <= accept;
            if (accept) begin
                ptr_reg    <= grant_idx;
                mul_in_reg <= req_data[int'(grant_idx)*64 +: 64];
            end
        end
    end

    assign mul_in     = mul_in_reg;
    assign mul_in_stb = mul_in_stb_reg;

    // Tag shift register: LAT+1 stages, shifts every cycle, bubbles enter as valid=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid_reg <= '0;
            for (int k = 0; k <= LAT; k++) begin
                tag_id_reg[k] <= '0;
            end
        end else begin
            tag_valid_reg <= {tag_valid_reg[LAT-1:0], accept};
            tag_id_reg[0] <= grant_idx;
            for (int k = 1; k <= LAT; k++) begin
                tag_id_reg[k] <= tag_id_reg[k-1];
            end
        end
    end

    // Sticky flag: a tag retired without the multiplier flagging a result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_err_reg <= 1'b0;
        end else if (retire_valid && !mul_z_stb) begin
            sync_err_reg <= 1'b1;
        end
    end

    assign sync_err = sync_err_reg;
    assign busy     = (|tag_valid_reg) | (|nonempty);

    // Per-requester credit accounting and response FIFO.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            logic [CW-1:0] count_reg;
            logic [CW-1:0] count_next;
            logic [CW-1:0] inflight_reg;
            logic [CW-1:0] inflight_next;
            logic [CW-1:0] credit;
            logic [AW-1:0] wr_ptr_reg;
            logic [AW-1:0] rd_ptr_reg;
            logic [31:0]   mem [DEPTH];
            logic          push;
            logic          pop;

            // count + inflight never exceeds DEPTH, so this cannot wrap.
            assign credit        = DEPTH_C - count_reg - inflight_reg;
            assign eligible[gi]  = req_valid[gi] && (credit != '0);
            assign push          = retire_valid && (retire_id == IDW'(gi));
            assign nonempty[gi]  = (count_reg != '0);
            assign pop           = nonempty[gi] && resp_ready[gi];
            assign resp_valid[gi] = nonempty[gi];
            assign resp_data[32*gi +: 32] = mem[rd_ptr_reg];

            // Occupancy and in-flight counters; simultaneous inc/dec cancel.
            always_comb begin
                count_next    = count_reg;
                inflight_next = inflight_reg;
                if (push && !pop) begin
                    count_next = count_reg + CW'(1);
                end else if (!push && pop) begin
                    count_next = count_reg - CW'(1);
                end
                if (grant[gi] && !push) begin
                    inflight_next = inflight_reg + CW'(1);
                end else if (!grant[gi] && push) begin
                    inflight_next = inflight_reg - CW'(1);
                end
            end

            // Counter and pointer registers; reset empties the FIFO.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    count_reg    <= '0;
                    inflight_reg <= '0;
                    wr_ptr_reg   <= '0;
                    rd_ptr_reg   <= '0;
                end else begin
                    count_reg    <= count_next;
                    inflight_reg <= inflight_next;
                    if (push) begin
                        wr_ptr_reg <= wr_ptr_reg + AW'(1);
                    end
                    if (pop) begin
                        rd_ptr_reg <= rd_ptr_reg + AW'(1);
                    end
                end
            end

            // FIFO storage; contents need no reset since pointers gate visibility.
            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_ptr_reg] <= mul_z;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Testbench for mul_rr_scheduler: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_mul_rr_scheduler;
    localparam int N     = 4;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [64*N-1:0]    req_data;
    logic [N-1:0]       req_ready;
    logic [63:0]        mul_in;
    logic               mul_in_stb;
    logic [31:0]        mul_z;
    logic               mul_z_stb;
    logic [N-1:0]       resp_valid;
    logic [32*N-1:0]    resp_data;
    logic [N-1:0]       resp_ready;
    logic               busy;
    logic               sync_err;

    mul_rr_scheduler #(.N_REQ(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .mul_in     (mul_in),
        .mul_in_stb (mul_in_stb),
        .mul_z      (mul_z),
        .mul_z_stb  (mul_z_stb),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_ready (resp_ready),
        .busy       (busy),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: exact for the operand pairs the bench uses.
    function automatic logic [31:0] fmul(logic [31:0] a, logic [31:0] b);
        if (b == 32'h3F80_0000) return a;
        if (a == 32'h3F80_0000) return b;
        if ((a == 32'h4000_0000 && b == 32'h4040_0000) ||
            (a == 32'h4040_0000 && b == 32'h4000_0000)) return 32'h40C0_0000;
        if (a == 32'h3FC0_0000 && b == 32'h3FC0_0000) return 32'h4010_0000;
        return a ^ b ^ 32'h5A5A_5A5A;
    endfunction

    // External pipelined multiplier: not stallable, not reset by rst.
    logic [31:0] sz   [LAT];
    logic        sstb [LAT];
    logic        stub_init;
    logic        stb_kill;

    always @(posedge clk) begin
        if (stub_init) begin
            for (int k = 0; k < LAT; k++) begin
                sz[k]   <= '0;
                sstb[k] <= 1'b0;
            end
        end else begin
            sz[0]   <= fmul(mul_in[63:32], mul_in[31:0]);
            sstb[0] <= mul_in_stb;
            for (int k = 1; k < LAT; k++) begin
                sz[k]   <= sz[k-1];
                sstb[k] <= sstb[k-1];
            end
        end
    end

    assign mul_z     = sz[LAT-1];
    assign mul_z_stb = sstb[LAT-1] & ~stb_kill;

    // Reference model: per-requester result queues and a list of issued ops.
    typedef struct {
        int          id;
        int          due;
        logic [31:0] z;
    } op_t;

    logic [31:0]  fq [N][$];
    op_t          pipe [$];
    int           m_ptr;
    logic         m_stb;
    logic [63:0]  m_mul_in;
    logic         m_sync;
    int           edge_cnt = 0;
    logic [N-1:0] last_rdy;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic int inflight_of(int i);
        int n = 0;
        foreach (pipe[j]) if (pipe[j].id == i) n++;
        return n;
    endfunction

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_data[64*i +: 64] = {a, b};
    endtask

    function automatic logic [31:0] rand_normal();
        logic [31:0] a;
        a = $urandom;
        a[30:23] = 8'($urandom_range(1, 254));
        return a;
    endfunction

    // One clock: check outputs against the model, then advance the model.
    task automatic cycle();
        int           g;
        int           idx;
        int           cr;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] pop_m;
        logic         stb_now;
        logic         any_q;
        op_t          op;
        #1;
        g = -1;
        if (!rst) begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_ptr + k) % N;
                cr  = DEPTH - fq[idx].size() - inflight_of(idx);
                if (g < 0 && req_valid[idx] && cr > 0) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        last_rdy = req_ready;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        any_q = 1'b0;
        for (int i = 0; i < N; i++) begin
            any_q    = any_q | (fq[i].size() != 0);
            pop_m[i] = (fq[i].size() != 0) && resp_ready[i];
            chk("resp_valid", 64'(resp_valid[i]), 64'(fq[i].size() != 0));
            if (fq[i].size() != 0)
                chk("resp_data", 64'(resp_data[32*i +: 32]), 64'(fq[i][0]));
        end
        chk("busy", 64'(busy), 64'((pipe.size() != 0) || any_q));
        chk("mul_in_stb", 64'(mul_in_stb), 64'(m_stb));
        chk("mul_in", mul_in, m_mul_in);
        chk("sync_err", 64'(sync_err), 64'(m_sync));
        stb_now = mul_z_stb;
        @(posedge clk);
        edge_cnt++;
        if (!rst) begin
            if (pipe.size() != 0 && pipe[0].due == edge_cnt) begin
                op = pipe.pop_front();
                chk("no_overflow", 64'(fq[op.id].size() < DEPTH), 64'd1);
                fq[op.id].push_back(op.z);
                if (!stb_now) m_sync = 1'b1;
            end
            for (int i = 0; i < N; i++)
                if (pop_m[i]) void'(fq[i].pop_front());
            if (g >= 0) begin
                pipe.push_back('{g, edge_cnt + LAT + 1,
                                 fmul(req_data[64*g+32 +: 32], req_data[64*g +: 32])});
                m_ptr    = g;
                m_stb    = 1'b1;
                m_mul_in = req_data[64*g +: 64];
            end else begin
                m_stb = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    // Reset for one cycle with requests pending, which must not be granted.
    task automatic do_reset();
        req_valid  = '1;
        resp_ready = '0;
        rst        = 1'b1;
        for (int i = 0; i < N; i++) fq[i].delete();
        pipe.delete();
        m_ptr    = N - 1;
        m_stb    = 1'b0;
        m_mul_in = '0;
        m_sync   = 1'b0;
        cycle();
        rst       = 1'b0;
        req_valid = '0;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int acc;
        logic [N-1:0] e;
        rst        = 1'b1;
        stub_init  = 1'b1;
        stb_kill   = 1'b0;
        req_valid  = '0;
        resp_ready = '0;
        req_data   = '0;
        @(negedge clk);
        do_reset();
        stub_init = 1'b0;
        chk("reset_ptr_grant0", 64'(busy), 64'd0);

        // Single op: 2.0 x 3.0 from requester 0.
        set_op(0, 32'h4000_0000, 32'h4040_0000);
        req_valid = 4'b0001;
        cycle();
        chk("single_accept", 64'(last_rdy), 64'h1);
        req_valid = '0;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!resp_valid[0] && n < 20);
        chk("single_latency", 64'(n), 64'd4);
        chk("single_data", 64'(resp_data[31:0]), 64'h40C0_0000);
        resp_ready = 4'b0001;
        cycle();
        resp_ready = '0;
        cycle();
        chk("single_busy_idle", 64'(busy), 64'd0);

        // Fairness: everyone valid, everyone draining.
        do_reset();
        req_valid  = '1;
        resp_ready = '1;
        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < N; i++) set_op(i, rand_normal(), 32'h3F80_0000);
            cycle();
            e = N'(1) << (k % N);
            chk("rr_grant", 64'(last_rdy), 64'(e));
        end
        idle(8);

        // Backpressure on requester 1.
        do_reset();
        set_op(1, 32'h3FC0_0000, 32'h3FC0_0000);
        req_valid = 4'b0010;
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (last_rdy[1]) acc++;
        end
        chk("bp_accepts", 64'(acc), 64'(DEPTH));
        resp_ready = 4'b0010;
        cycle();
        resp_ready = '0;
        cycle();
        chk("bp_reaccept", 64'(last_rdy[1]), 64'd1);
        cycle();
        chk("bp_hold", 64'(last_rdy[1]), 64'd0);
        req_valid  = '0;
        resp_ready = 4'b0010;
        for (int k = 0; k < 12; k++) begin
            if (resp_valid[1]) chk("bp_data", 64'(resp_data[63:32]), 64'h4010_0000);
            cycle();
        end

        // Simultaneous push and pop on FIFO 2.
        do_reset();
        set_op(2, 32'h4000_0000, 32'h4040_0000);
        req_valid = 4'b0100;
        cycle();
        idle(5);
        set_op(2, 32'h3FC0_0000, 32'h3FC0_0000);
        req_valid = 4'b0100;
        cycle();
        idle(3);
        resp_ready = 4'b0100;
        cycle();
        resp_ready = '0;
        chk("pp_valid", 64'(resp_valid[2]), 64'd1);
        chk("pp_data", 64'(resp_data[95:64]), 64'h4010_0000);
        resp_ready = 4'b0100;
        cycle();
        resp_ready = '0;
        chk("pp_empty", 64'(resp_valid[2]), 64'd0);

        // Reset while three operations are in flight.
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, rand_normal(), 32'h3F80_0000);
        req_valid = 4'b0111;
        repeat (3) cycle();
        do_reset();
        idle(8);
        chk("midrst_resp", 64'(resp_valid), 64'd0);
        chk("midrst_sync", 64'(sync_err), 64'd0);

        // Randomized traffic.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            req_valid  = N'($urandom);
            resp_ready = N'($urandom);
            for (int i = 0; i < N; i++) set_op(i, rand_normal(), 32'h3F80_0000);
            cycle();
        end
        resp_ready = '1;
        idle(12);
        chk("random_drained", 64'(busy), 64'd0);

        // Result strobe missing when a tag retires.
        do_reset();
        stb_kill = 1'b1;
        set_op(0, 32'h4000_0000, 32'h4040_0000);
        req_valid = 4'b0001;
        cycle();
        idle(6);
        chk("sync_latched", 64'(sync_err), 64'd1);
        stb_kill   = 1'b0;
        resp_ready = '1;
        idle(4);
        chk("sync_sticky", 64'(sync_err), 64'd1);
        do_reset();
        chk("sync_cleared", 64'(sync_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
